// File: rtl/serial_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_pkg
// Description : Types and constants shared by the serializer and the
//               deserializer on either side of the serial link.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_pkg;

  // Word size carried across the link by both ends
  localparam int WORD_WIDTH = 8;

  // Transmitter states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } ser_state_e;

endpackage : serial_pkg
`default_nettype wire

// File: rtl/serializer.sv
`default_nettype none
// ============================================================================
// Module      : serializer
// Description : Parallel-to-serial transmitter. Pulls a word over a valid/ack
//               handshake and shifts it out MSB first, framed by write_out,
//               followed by an optional idle gap.
// Revision    : 1.0 - initial release
// ============================================================================
module serializer
  import serial_pkg::*;
#(
  parameter int WIDTH      = WORD_WIDTH,
  parameter int BIT_CYCLES = 1,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic             ack_out,
  output logic             data_out,
  output logic             write_out,
  output logic             status_out
);

  // A zero-length gap still needs a one-bit counter to keep the code legal
  localparam int c_tick_w = $clog2(BIT_CYCLES + 1);
  localparam int c_bit_w  = $clog2(WIDTH + 1);
  localparam int c_gap_w  = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(BIT_CYCLES - 1);
  localparam logic [c_bit_w-1:0]  c_bit_last  = c_bit_w'(WIDTH - 1);
  localparam logic [c_gap_w-1:0]  c_gap_last  = c_gap_w'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  ser_state_e          state_q, state_d;
  logic [WIDTH-1:0]    shift_q, shift_d;
  logic [c_tick_w-1:0] tick_q,  tick_d;
  logic [c_bit_w-1:0]  bit_q,   bit_d;
  logic [c_gap_w-1:0]  gap_q,   gap_d;
  logic                ack_q,   ack_d;
  logic                data_q,  data_d;
  logic                write_q, write_d;
  logic                status_q, status_d;

  // Next-state and next-output logic; outputs are derived from the next state
  // so that they are valid in the very cycle after the transition edge
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    ack_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (valid_in) begin
          shift_d = data_in;
          tick_d  = '0;
          bit_d   = '0;
          ack_d   = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (tick_q == c_tick_last) begin
          shift_d = {shift_q[WIDTH-2:0], 1'b0};
          tick_d  = '0;
          bit_d   = bit_q + c_bit_w'(1);
          if (bit_q == c_bit_last) begin
            gap_d   = '0;
            state_d = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
          end
        end else begin
          tick_d = tick_q + c_tick_w'(1);
        end
      end
      ST_GAP: begin
        if (gap_q == c_gap_last) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + c_gap_w'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    write_d  = (state_d == ST_SHIFT);
    data_d   = write_d & shift_d[WIDTH-1];
    status_d = (state_d != ST_IDLE);
  end

  // State, counters and registered outputs; reset discards any word in flight
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      shift_q  <= '0;
      tick_q   <= '0;
      bit_q    <= '0;
      gap_q    <= '0;
      ack_q    <= 1'b0;
      data_q   <= 1'b0;
      write_q  <= 1'b0;
      status_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      tick_q   <= tick_d;
      bit_q    <= bit_d;
      gap_q    <= gap_d;
      ack_q    <= ack_d;
      data_q   <= data_d;
      write_q  <= write_d;
      status_q <= status_d;
    end
  end

  assign ack_out    = ack_q;
  assign data_out   = data_q;
  assign write_out  = write_q;
  assign status_out = status_q;

endmodule : serializer
`default_nettype wire

// File: tb/tb_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_serializer
// Description : Self-checking bench for serializer. Two instances: defaults
//               (A) and slow bits with no gap (B). A timing model predicts
//               every output cycle by cycle; directed words are also decoded
//               and checked against literal values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serializer;

  localparam int BC_A = 1, GAP_A = 1;
  localparam int BC_B = 4, GAP_B = 0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] da = '0, db = '0;
  logic       va = 1'b0, vb = 1'b0;
  logic       ack_a, data_a, write_a, status_a;
  logic       ack_b, data_b, write_b, status_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serializer #(.WIDTH(8), .BIT_CYCLES(BC_A), .GAP_CYCLES(GAP_A)) u_a (
    .clock(clk), .reset(rst_n), .data_in(da), .valid_in(va),
    .ack_out(ack_a), .data_out(data_a), .write_out(write_a), .status_out(status_a));

  serializer #(.WIDTH(8), .BIT_CYCLES(BC_B), .GAP_CYCLES(GAP_B)) u_b (
    .clock(clk), .reset(rst_n), .data_in(db), .valid_in(vb),
    .ack_out(ack_b), .data_out(data_b), .write_out(write_b), .status_out(status_b));

  // ---------------- timing model: elapsed edges since the accept edge -------
  logic       busy_ma = 1'b0, busy_mb = 1'b0;
  int         n_ma = 0, n_mb = 0;
  logic [7:0] w_ma = '0, w_mb = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_ma <= 1'b0; n_ma <= 0;
    end else if (!busy_ma) begin
      if (va) begin busy_ma <= 1'b1; n_ma <= 0; w_ma <= da; end
    end else begin
      if (n_ma + 1 == 8 * BC_A + GAP_A) busy_ma <= 1'b0;
      n_ma <= n_ma + 1;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_mb <= 1'b0; n_mb <= 0;
    end else if (!busy_mb) begin
      if (vb) begin busy_mb <= 1'b1; n_mb <= 0; w_mb <= db; end
    end else begin
      if (n_mb + 1 == 8 * BC_B + GAP_B) busy_mb <= 1'b0;
      n_mb <= n_mb + 1;
    end
  end

  // {ack, data, write, status} expected n edges after the accept edge
  function automatic logic [3:0] expect_out(logic busy, int n, logic [7:0] w, int bc);
    logic a, d, wr;
    if (!busy) return 4'b0000;
    a  = (n == 0);
    wr = (n < 8 * bc);
    d  = wr ? w[7 - n / bc] : 1'b0;
    return {a, d, wr, 1'b1};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    check("cycle_a", {28'd0, ack_a, data_a, write_a, status_a},
          {28'd0, expect_out(busy_ma, n_ma, w_ma, BC_A)});
    check("cycle_b", {28'd0, ack_b, data_b, write_b, status_b},
          {28'd0, expect_out(busy_mb, n_mb, w_mb, BC_B)});
  end

  // ---------------- receiver-side observers --------------------------------
  logic [7:0] words_a[$], words_b[$];
  int         ack_cyc_a[$], ack_cyc_b[$];
  int         lowrun_a[$], hirun_b[$];
  logic [7:0] sh_a = '0, sh_b = '0;
  int         nb_a = 0, nb_b = 0, low_a = 0, hi_b = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      nb_a = 0; nb_b = 0; hi_b = 0; low_a = 0;
    end else begin
      if (ack_a) ack_cyc_a.push_back(cyc);
      if (ack_b) ack_cyc_b.push_back(cyc);
      if (write_a) begin
        if (low_a > 0) lowrun_a.push_back(low_a);
        low_a = 0;
        sh_a = {sh_a[6:0], data_a};
        nb_a++;
        if (nb_a == 8) begin words_a.push_back(sh_a); nb_a = 0; end
      end else begin
        low_a++;
      end
      if (write_b) begin
        if (hi_b % BC_B == 0) begin
          sh_b = {sh_b[6:0], data_b};
          nb_b++;
          if (nb_b == 8) begin words_b.push_back(sh_b); nb_b = 0; end
        end
        hi_b++;
      end else begin
        if (hi_b > 0) hirun_b.push_back(hi_b);
        hi_b = 0;
      end
    end
  end

  // ---------------- stimulus helpers ---------------------------------------
  task automatic pulse_a(logic [7:0] d);
    @(negedge clk); #1; va = 1'b1; da = d;
    @(negedge clk); #1; va = 1'b0;
  endtask

  task automatic wait_ack(logic which_b, string name);
    bit seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      seen = which_b ? ack_b : ack_a;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL %s: got no ack, expected ack within 60 cycles", name);
    end
    #1;
  endtask

  // ---------------- directed sequence --------------------------------------
  initial begin
    // Reset held for 3 cycles, valid low
    repeat (3) @(negedge clk);
    check("reset_outputs", {24'd0, ack_a, data_a, write_a, status_a, ack_b, data_b, write_b, status_b}, 32'd0);
    #1; rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Basic word
    pulse_a(8'hA5);
    repeat (12) @(negedge clk);

    // Back-to-back with valid held
    #1; va = 1'b1; da = 8'h3C;
    wait_ack(1'b0, "ack_3c");
    da = 8'hC3;
    wait_ack(1'b0, "ack_c3");
    va = 1'b0;
    repeat (12) @(negedge clk);

    // Valid toggling while busy must be ignored
    pulse_a(8'h96);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1; va = 1'b1;
      @(negedge clk); #1; va = 1'b0;
    end
    repeat (8) @(negedge clk);

    // Reset right after bit 3 of 0xFF
    pulse_a(8'hFF);
    repeat (3) @(negedge clk);
    #1; rst_n = 1'b0;
    #1;
    check("reset_drop", {29'd0, write_a, data_a, status_a}, 32'd0);
    repeat (2) @(negedge clk);
    #1; rst_n = 1'b1;
    repeat (2) @(negedge clk);
    pulse_a(8'h0F);
    repeat (12) @(negedge clk);

    // Slow bits, no gap, valid held for two words
    #1; vb = 1'b1; db = 8'h81;
    wait_ack(1'b1, "ack_81");
    db = 8'h42;
    wait_ack(1'b1, "ack_42");
    vb = 1'b0;
    repeat (40) @(negedge clk);

    // Literal expectations
    check("a_word_count", words_a.size(), 5);
    if (words_a.size() == 5) begin
      check("a_word0", words_a[0], 8'hA5);
      check("a_word1", words_a[1], 8'h3C);
      check("a_word2", words_a[2], 8'hC3);
      check("a_word3", words_a[3], 8'h96);
      check("a_word4", words_a[4], 8'h0F);
    end
    check("a_ack_count", ack_cyc_a.size(), 6);
    if (ack_cyc_a.size() >= 3)
      check("a_b2b_period", ack_cyc_a[2] - ack_cyc_a[1], 10);
    if (lowrun_a.size() >= 3)
      check("a_b2b_low", lowrun_a[2], 2);
    else
      check("a_lowrun_count", lowrun_a.size(), 3);
    check("b_word_count", words_b.size(), 2);
    if (words_b.size() == 2) begin
      check("b_word0", words_b[0], 8'h81);
      check("b_word1", words_b[1], 8'h42);
    end
    check("b_ack_count", ack_cyc_b.size(), 2);
    if (ack_cyc_b.size() == 2)
      check("b_period", ack_cyc_b[1] - ack_cyc_b[0], 33);
    if (hirun_b.size() >= 1)
      check("b_write_len", hirun_b[0], 32);
    else
      check("b_run_count", hirun_b.size(), 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_serializer
`default_nettype wire
